// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults and FSM state encoding for the rf_multiport register file
package rf_pkg;

    localparam int RF_DW_DEF = 32;
    localparam int RF_AW_DEF = 5;
    localparam int RF_NR_DEF = 2;

    typedef enum logic {
        RF_ST_CLEAR = 1'b0,
        RF_ST_RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one registered read port: zero-reg mux, optional bypass (RF_BYPASS_EN), output register
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DW       = RF_DW_DEF,
    parameter int AW       = RF_AW_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          state,
    input  logic [AW-1:0] raddr,
    input  logic [DW-1:0] mem_word,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic          zero_hit;
    logic [DW-1:0] rdata_nxt;

    assign zero_hit = (ZERO_REG != 0) && (raddr == '0);

`ifdef RF_BYPASS_EN
    // When the addresses match, zero_hit also covers the write-to-entry-0 exclusion.
    always_comb begin
        rdata_nxt = mem_word;
        if (we && (waddr == raddr))
            rdata_nxt = wdata;
        if (zero_hit)
            rdata_nxt = '0;
    end
`else
    logic unused_wport;
    assign unused_wport = &{1'b0, we, waddr, wdata};

    always_comb begin
        rdata_nxt = mem_word;
        if (zero_hit)
            rdata_nxt = '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst || (state != RF_ST_RUN))
            rdata <= '0;
        else
            rdata <= rdata_nxt;
    end

endmodule

// File: rtl/rf_multiport.sv
// rtl/rf_multiport.sv - NR-read/1-write register file with clear sweep; RF_BYPASS_EN enables write-to-read bypass
module rf_multiport
    import rf_pkg::*;
#(
    parameter int DW       = RF_DW_DEF,
    parameter int AW       = RF_AW_DEF,
    parameter int NR       = RF_NR_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR*DW-1:0] rdata,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [DW-1:0]    wdata,
    output logic             ready
);

    localparam logic [AW-1:0] PTR_LAST = '1;

    logic [DW-1:0] mem [2**AW];
    rf_state_e     state;
    logic [AW-1:0] ptr;
    logic          wr_ok;

    assign wr_ok = we && !((ZERO_REG != 0) && (waddr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RF_ST_CLEAR;
            ptr   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                RF_ST_CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == PTR_LAST) begin
                        state <= RF_ST_RUN;
                        ready <= 1'b1;
                    end
                end
                RF_ST_RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= RF_ST_CLEAR;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // The sweep owns the array while clearing; writes from WB are dropped until RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == RF_ST_CLEAR)
                mem[ptr] <= '0;
            else if (wr_ok)
                mem[waddr] <= wdata;
        end
    end

    for (genvar i = 0; i < NR; i++) begin : g_rd
        rf_read_port #(
            .DW       (DW),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .clk      (clk),
            .rst      (rst),
            .state    (state),
            .raddr    (raddr[i*AW +: AW]),
            .mem_word (mem[raddr[i*AW +: AW]]),
            .we       (we),
            .waddr    (waddr),
            .wdata    (wdata),
            .rdata    (rdata[i*DW +: DW])
        );
    end

endmodule
